// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the IF-stage program-counter unit.
//   PC_XLEN              - address width the pending-redirect record is built for
//   DEFAULT_RESET_VECTOR - first fetch address after reset
//   DEFAULT_INC          - byte step per sequential fetch
//   pc_state_e           - BOOT (first cycle out of reset) / RUN
//   pend_redirect_t      - redirect captured while the front end is held
package pc_pkg;

  localparam int                  PC_XLEN              = 32;
  localparam logic [PC_XLEN-1:0]  DEFAULT_RESET_VECTOR = '0;
  localparam int                  DEFAULT_INC          = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  typedef struct packed {
    logic               valid;
    logic               is_trap;
    logic [PC_XLEN-1:0] addr;
  } pend_redirect_t;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: hazard/EX/trap control into the PC unit and the fetch address
// plus status back out to the IF/ID stage.
//   master - the pipeline side: drives STALL, IMEM_READY, BRANCH_*, TRAP*,
//            receives PC, PC_PLUS4, FETCH_VALID, REDIRECTED, MISALIGN_ERR
//   slave  - the PC unit side (directions mirrored)
interface pc_unit_if #(
  parameter int XLEN = pc_pkg::PC_XLEN
);

  logic            STALL;
  logic            IMEM_READY;
  logic            BRANCH_TAKEN;
  logic [XLEN-1:0] BRANCH_TARGET;
  logic            TRAP;
  logic [XLEN-1:0] TRAP_VECTOR;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_PLUS4;
  logic            FETCH_VALID;
  logic            REDIRECTED;
  logic            MISALIGN_ERR;

  modport master (
    output STALL, IMEM_READY, BRANCH_TAKEN, BRANCH_TARGET, TRAP, TRAP_VECTOR,
    input  PC, PC_PLUS4, FETCH_VALID, REDIRECTED, MISALIGN_ERR
  );

  modport slave (
    input  STALL, IMEM_READY, BRANCH_TAKEN, BRANCH_TARGET, TRAP, TRAP_VECTOR,
    output PC, PC_PLUS4, FETCH_VALID, REDIRECTED, MISALIGN_ERR
  );

endinterface

// File: rtl/pc_pending_redirect.sv
// pc_pending_redirect: one-entry buffer for a redirect that arrives while
// the front end is held.
//   clk, rst      - clock, synchronous active-high reset (clears the entry)
//   en            - unit is in RUN; redirects seen in BOOT are ignored
//   hold          - STALL | ~IMEM_READY
//   trap, trap_vector, branch_taken, branch_target - redirect requests
//   pend_valid    - an entry is waiting to be applied
//   pend_addr     - its raw (unaligned) target address
// A trap replaces any entry; a branch replaces only a branch entry. The
// entry is dropped on the first un-held edge, whether it drains there or a
// newer redirect is applied directly on that edge.
module pc_pending_redirect
  import pc_pkg::*;
#(
  parameter int XLEN = PC_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            hold,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_addr
);

  pend_redirect_t pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q.valid   <= 1'b0;
      pend_q.is_trap <= 1'b0;
    end else if (en) begin
      if (hold) begin
        if (trap) begin
          pend_q.valid   <= 1'b1;
          pend_q.is_trap <= 1'b1;
          pend_q.addr    <= trap_vector;
        end else if (branch_taken && !(pend_q.valid && pend_q.is_trap)) begin
          pend_q.valid   <= 1'b1;
          pend_q.is_trap <= 1'b0;
          pend_q.addr    <= branch_target;
        end
      end else begin
        pend_q.valid   <= 1'b0;
        pend_q.is_trap <= 1'b0;
      end
    end
  end

  assign pend_valid = pend_q.valid;
  assign pend_addr  = pend_q.addr;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter for the IF stage.
//   CLOCK, RESET - clock, synchronous active-high reset
//   bus (slave)  - STALL/IMEM_READY hold, BRANCH_TAKEN/BRANCH_TARGET,
//                  TRAP/TRAP_VECTOR in; PC, PC_PLUS4 (combinational),
//                  FETCH_VALID, REDIRECTED, MISALIGN_ERR out
// Redirect priority per edge: trap, branch, buffered redirect, hold,
// sequential increment. A redirect seen under hold is parked in
// pc_pending_redirect and applied on the first un-held edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int              INC          = DEFAULT_INC
) (
  input  logic      CLOCK,
  input  logic      RESET,
  pc_unit_if.slave  bus
);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    return |a[1:0];
  endfunction

  pc_state_e       state;
  logic [XLEN-1:0] pc_q;
  logic            fetch_valid_q;
  logic            redirected_q;
  logic            misalign_q;

  logic            hold;
  logic            redir_req;
  logic [XLEN-1:0] redir_tgt;
  logic            pend_valid;
  logic [XLEN-1:0] pend_addr;

  assign hold      = bus.STALL | ~bus.IMEM_READY;
  assign redir_req = bus.TRAP | bus.BRANCH_TAKEN;
  assign redir_tgt = bus.TRAP ? bus.TRAP_VECTOR : bus.BRANCH_TARGET;

  pc_pending_redirect #(
    .XLEN (XLEN)
  ) u_pending (
    .clk           (CLOCK),
    .rst           (RESET),
    .en            (state == RUN),
    .hold          (hold),
    .trap          (bus.TRAP),
    .trap_vector   (bus.TRAP_VECTOR),
    .branch_taken  (bus.BRANCH_TAKEN),
    .branch_target (bus.BRANCH_TARGET),
    .pend_valid    (pend_valid),
    .pend_addr     (pend_addr)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      redirected_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      // Flush and misalign flags are one-cycle pulses unless re-set below.
      redirected_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state)
        BOOT: begin
          // First fetch is RESET_VECTOR itself, so PC is left alone here.
          state         <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (redir_req && !hold) begin
            pc_q         <= align_word(redir_tgt);
            redirected_q <= 1'b1;
            misalign_q   <= is_misaligned(redir_tgt);
          end else if (pend_valid && !hold && !redir_req) begin
            pc_q         <= align_word(pend_addr);
            redirected_q <= 1'b1;
            misalign_q   <= is_misaligned(pend_addr);
          end else if (!hold) begin
            pc_q <= pc_q + XLEN'(INC);
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.PC           = pc_q;
  assign bus.PC_PLUS4     = pc_q + XLEN'(INC);
  assign bus.FETCH_VALID  = fetch_valid_q;
  assign bus.REDIRECTED   = redirected_q;
  assign bus.MISALIGN_ERR = misalign_q;

endmodule
